muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32: operand/result width; the legal range is an even value >= 4.
REQ-002 The module SHALL provide port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 The module SHALL provide port reset_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 The module SHALL provide port start, input, 1 bit: request a new operation; honoured only in IDLE.
REQ-005 The module SHALL provide port funct3, input, 3 bits, with this encoding: 000 mul; 001 mulh; 010 mulhsu; 011 mulhu; 100 div; 101 divu; 110 rem; 111 remu.
REQ-006 The module SHALL provide port op_a, input, XLEN bits: rs1 operand, the multiplicand or dividend.
REQ-007 The module SHALL provide port op_b, input, XLEN bits: rs2 operand, the multiplier or divisor.
REQ-008 The module SHALL provide port flush, input, 1 bit: abort any operation in progress.
REQ-009 The module SHALL provide port busy, output, 1 bit: high whenever state is not IDLE, used by the pipeline as the stall request.
REQ-010 The module SHALL provide port done, output, 1 bit: a single-cycle pulse marking result as valid.
REQ-011 The module SHALL provide port result, output, XLEN bits: the operation result.

Function
REQ-012 States: IDLE, CALC, DONE; the implementation uses no other states.
REQ-013 In IDLE, start=1 and flush=0 latch funct3, op_a and op_b on the clock edge, load iteration counter = XLEN, and move to CALC.
REQ-014 A start received in CALC or DONE is ignored; the unit does not queue it.
REQ-015 CALC performs one iteration per cycle and decrements the counter; multiplication is a shift-add on magnitudes, one multiplier bit per cycle; division is restoring, one quotient bit per cycle.
REQ-016 After XLEN CALC cycles the unit moves to DONE; done=1 for exactly the one DONE cycle; the next state is IDLE.
REQ-017 Latency: done SHALL assert XLEN+1 cycles after the accepting edge (33 cycles for XLEN=32).
REQ-018 Signedness: mul/mulh/div/rem treat both operands as signed; mulhsu treats op_a as signed and op_b as unsigned; mulhu/divu/remu treat both as unsigned.
REQ-019 Signed operations run on absolute values, and the sign is corrected when result is registered on entry to DONE.
REQ-020 Product is 2*XLEN bits: mul returns the low XLEN bits; mulh, mulhsu and mulhu return the high XLEN bits.
REQ-021 Remainder sign follows the dividend; quotient rounds toward zero.
REQ-022 Divide by zero (div, divu, rem, remu with op_b=0): quotient = all ones, remainder = op_a; this path skips CALC and enters DONE on the cycle after acceptance (latency 1).
REQ-023 Signed overflow (div or rem, op_a = most-negative, op_b = all ones): quotient = op_a, remainder = 0; this path skips CALC and enters DONE on the cycle after acceptance (latency 1).
REQ-024 result SHALL be registered and hold its value from DONE until the next DONE; it does not change during CALC.
REQ-025 flush=1 in any state forces IDLE on the next edge with done=0 and result unchanged; flush has priority over start in the same cycle.
REQ-026 Multiply by zero still takes the full XLEN+1 latency; the unit has no early-out.

Reset
REQ-027 reset_n=0 at a clock edge SHALL force state=IDLE, counter=0, busy=0, done=0, result=0, and clear all operand/accumulator registers.
REQ-028 Reset SHALL take priority over flush and start, and a reset mid-CALC discards the operation without a done pulse.
REQ-029 The first start after reset_n returns high is accepted normally.

Verification
REQ-030 The bench SHALL cover mul with op_a=7, op_b=0xFFFFFFFD -> done 33 cycles after accept, result=0xFFFFFFEB, busy high for 33 cycles.
REQ-031 The bench SHALL cover mulhu with op_a=op_b=0xFFFFFFFF -> result=0xFFFFFFFE; mulh with the same operands -> result=0x00000000; mulhsu with op_a=0xFFFFFFFF, op_b=2 -> result=0xFFFFFFFF.
REQ-032 The bench SHALL cover div with op_a=0xFFFFFFF9 (-7), op_b=2 -> result=0xFFFFFFFD; rem with the same operands -> 0xFFFFFFFF; remu with op_a=7, op_b=2 -> 1.
REQ-033 The bench SHALL cover divu with op_b=0 -> result=0xFFFFFFFF with done 1 cycle after accept; div with op_a=0x80000000, op_b=0xFFFFFFFF -> 0x80000000 at 1 cycle; rem with the same operands -> 0.
REQ-034 The bench SHALL cover flush asserted 10 cycles into a div -> busy=0 next cycle, no done pulse, result retains its prior value; start re-asserted the same cycle as flush is ignored.
REQ-035 The bench SHALL cover reset_n=0 mid-CALC -> next cycle all outputs are 0; start held high during CALC is not re-accepted until IDLE; XLEN=8 regression of the REQ-030 to REQ-033 cases, scaled to 8 bits.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply and
// restoring divide, one bit per cycle, with single-cycle divide special cases.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, next_state;
    logic [CW-1:0]     count;
    logic [2:0]        fn;
    logic              neg;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;

    logic              is_div, a_signed, b_signed, a_neg, b_neg;
    logic              div_zero, div_ovf, fast, accept, neg_in;
    logic [XLEN-1:0]   a_mag, b_mag, fast_result;

    logic [XLEN:0]     add_sum, r_sh;
    logic              ge;
    logic [XLEN-1:0]   sub_lo, quo, rem, calc_result;
    logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod;

    // Operand decode: signedness, magnitudes and the single-cycle divide cases
    always_comb begin
        is_div   = funct3[2];
        a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed = is_div ? ~funct3[0] : ~funct3[1];
        a_neg    = a_signed & op_a[XLEN-1];
        b_neg    = b_signed & op_b[XLEN-1];
        a_mag    = a_neg ? (ZERO - op_a) : op_a;
        b_mag    = b_neg ? (ZERO - op_b) : op_b;
        // remainder takes the dividend's sign, everything else the xor
        neg_in   = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div && (op_b == ZERO);
        div_ovf  = is_div && !funct3[0] && (op_a == MOST_NEG) && (op_b == ALL_ONES);
        fast     = div_zero | div_ovf;
        if (div_zero) begin
            fast_result = funct3[1] ? op_a : ALL_ONES;
        end else if (div_ovf) begin
            fast_result = funct3[1] ? ZERO : op_a;
        end else begin
            fast_result = ZERO;
        end
        accept = (state == IDLE) && start && !flush;
    end

    // One iteration step and the sign-corrected final result
    always_comb begin
        add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        mul_next = {add_sum, acc[XLEN-1:1]};
        r_sh     = acc[2*XLEN-1:XLEN-1];
        ge       = (r_sh >= {1'b0, opnd});
        sub_lo   = r_sh[XLEN-1:0] - opnd;
        div_next = ge ? {sub_lo, acc[XLEN-2:0], 1'b1} : {r_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        acc_next = fn[2] ? div_next : mul_next;
        prod     = neg ? ({(2*XLEN){1'b0}} - acc_next) : acc_next;
        quo      = neg ? (ZERO - acc_next[XLEN-1:0]) : acc_next[XLEN-1:0];
        rem      = neg ? (ZERO - acc_next[2*XLEN-1:XLEN]) : acc_next[2*XLEN-1:XLEN];
        if (fn[2]) begin
            calc_result = fn[1] ? rem : quo;
        end else begin
            calc_result = (fn[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = fast ? DONE : CALC;
                end else begin
                    next_state = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    next_state = IDLE;
                end else if (count == CW'(1)) begin
                    next_state = DONE;
                end else begin
                    next_state = CALC;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register with registered status outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            done  <= (next_state == DONE);
        end
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count  <= {CW{1'b0}};
            fn     <= 3'b000;
            neg    <= 1'b0;
            opnd   <= ZERO;
            acc    <= {(2*XLEN){1'b0}};
            result <= ZERO;
        end else if (accept) begin
            fn    <= funct3;
            neg   <= neg_in;
            opnd  <= is_div ? b_mag : a_mag;
            acc   <= {ZERO, (is_div ? a_mag : b_mag)};
            count <= CW'(XLEN);
            if (fast) begin
                result <= fast_result;
            end
        end else if ((state == CALC) && !flush) begin
            acc   <= acc_next;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
                result <= calc_result;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32 and XLEN=8.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        start32, busy32, done32;
    logic [31:0] result32;
    logic        start8, busy8, done8;
    logic [7:0]  result8;

    logic        sel8;
    logic        cur_busy, cur_done;
    logic [31:0] cur_res;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .start(start32), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .busy(busy32), .done(done32), .result(result32)
    );

    muldiv_unit #(.XLEN(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .funct3(funct3),
        .op_a(op_a[7:0]), .op_b(op_b[7:0]), .flush(flush),
        .busy(busy8), .done(done8), .result(result8)
    );

    assign cur_busy = sel8 ? busy8 : busy32;
    assign cur_done = sel8 ? done8 : done32;
    assign cur_res  = sel8 ? {24'h000000, result8} : result32;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, busy length, result and hold behaviour.
    task automatic do_op(input logic w8, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input string tag);
        int lat, busy_cnt;
        logic [31:0] prev;
        logic stable;
        lat = 0;
        busy_cnt = 0;
        stable = 1'b1;
        sel8 = w8;
        @(negedge clk);
        prev = cur_res;
        funct3 = f;
        op_a = a;
        op_b = b;
        if (w8) start8 = 1'b1;
        else    start32 = 1'b1;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            start32 = 1'b0;
            if (cur_busy) busy_cnt++;
            if (cur_done) lat = k;
            else if (cur_res !== prev) stable = 1'b0;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
        check({tag, "_result"}, cur_res, exp_res);
        check({tag, "_result_held"}, {31'd0, stable}, 32'd1);
        @(negedge clk);
        check({tag, "_idle_after"}, {30'd0, cur_busy, cur_done}, 32'd0);
    endtask

    initial begin
        int ndone, nact;
        reset_n = 1'b0;
        flush = 1'b0;
        funct3 = 3'b000;
        op_a = 32'd0;
        op_b = 32'd0;
        start32 = 1'b0;
        start8 = 1'b0;
        sel8 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst32_status", {30'd0, busy32, done32}, 32'd0);
        check("rst32_result", result32, 32'd0);
        check("rst8_status", {30'd0, busy8, done8}, 32'd0);
        check("rst8_result", {24'd0, result8}, 32'd0);
        reset_n = 1'b1;

        do_op(1'b0, 3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul32");
        do_op(1'b0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu32");
        do_op(1'b0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, "mulh32");
        do_op(1'b0, 3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33, "mulhsu32");
        do_op(1'b0, 3'b000, 32'h00001234, 32'h00000000, 32'h00000000, 33, "mulzero32");
        do_op(1'b0, 3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, "div32");
        do_op(1'b0, 3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, "rem32");
        do_op(1'b0, 3'b111, 32'h00000007, 32'h00000002, 32'h00000001, 33, "remu32");
        do_op(1'b0, 3'b101, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1, "divu0_32");
        do_op(1'b0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "divovf32");
        do_op(1'b0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, "removf32");
        do_op(1'b0, 3'b111, 32'h00000055, 32'h00000000, 32'h00000055, 1, "remu0_32");

        do_op(1'b1, 3'b000, 32'h07, 32'hFD, 32'hEB, 9, "mul8");
        do_op(1'b1, 3'b011, 32'hFF, 32'hFF, 32'hFE, 9, "mulhu8");
        do_op(1'b1, 3'b001, 32'hFF, 32'hFF, 32'h00, 9, "mulh8");
        do_op(1'b1, 3'b010, 32'hFF, 32'h02, 32'hFF, 9, "mulhsu8");
        do_op(1'b1, 3'b100, 32'hF9, 32'h02, 32'hFD, 9, "div8");
        do_op(1'b1, 3'b110, 32'hF9, 32'h02, 32'hFF, 9, "rem8");
        do_op(1'b1, 3'b111, 32'h07, 32'h02, 32'h01, 9, "remu8");
        do_op(1'b1, 3'b101, 32'h34, 32'h00, 32'hFF, 1, "divu0_8");
        do_op(1'b1, 3'b100, 32'h80, 32'hFF, 32'h80, 1, "divovf8");
        do_op(1'b1, 3'b110, 32'h80, 32'hFF, 32'h00, 1, "removf8");

        // Flush ten cycles into a divide, with a competing start on the same cycle.
        sel8 = 1'b0;
        @(negedge clk);
        funct3 = 3'b100;
        op_a = 32'd100;
        op_b = 32'd3;
        start32 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start32 = 1'b0;
        end
        flush = 1'b1;
        start32 = 1'b1;
        funct3 = 3'b101;
        op_b = 32'd0;
        @(negedge clk);
        check("flush_status", {30'd0, busy32, done32}, 32'd0);
        check("flush_result", result32, 32'h00000055);
        flush = 1'b0;
        start32 = 1'b0;
        nact = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy32 || done32) nact++;
        end
        check("flush_quiet", nact, 0);

        // Start held high through CALC, then reset mid-CALC of the re-accepted op.
        funct3 = 3'b000;
        op_a = 32'd3;
        op_b = 32'd5;
        start32 = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k <= 34 && done32) ndone++;
            if (k == 33) check("hold_done", {31'd0, done32}, 32'd1);
            if (k == 33) check("hold_result", result32, 32'd15);
            if (k == 34) check("hold_idle_gap", {31'd0, busy32}, 32'd0);
            if (k == 35) check("hold_reaccept", {31'd0, busy32}, 32'd1);
        end
        check("hold_single_done", ndone, 1);
        reset_n = 1'b0;
        start32 = 1'b0;
        @(negedge clk);
        check("midrst_status", {30'd0, busy32, done32}, 32'd0);
        check("midrst_result", result32, 32'd0);
        reset_n = 1'b1;
        do_op(1'b0, 3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
